// File: rtl/pwm_shadow_bank.sv
// Double-buffered multi-channel register bank for the PWM datapath.
// Software writes land in staging registers. A commit arms a bank-wide copy
// into the active registers, which happens atomically on the boundary chosen
// by update_mode. While PWM is off, the active registers follow staging.
module pwm_shadow_bank #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIV_W    = 8,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      pwm_onoff,
    input  logic                      mask_event,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
    input  logic [1:0]                update_mode,
    input  logic [DIV_W-1:0]          event_div,
    output logic [CHANNELS*WIDTH-1:0] reg_out,
    output logic                      pending,
    output logic                      update_pulse
);

    localparam logic       PWM_ON   = 1'b1;
    localparam logic [1:0] MODE_IMM = 2'd0;
    localparam logic [1:0] MODE_EVT = 2'd1;
    localparam logic [1:0] MODE_DIV = 2'd2;

    logic [CHANNELS-1:0][WIDTH-1:0] staging;
    logic [CHANNELS-1:0][WIDTH-1:0] active;
    logic [DIV_W-1:0]               evt_cnt;
    logic [DIV_W-1:0]               evt_cnt_d;
    logic                           pending_d;
    logic                           xfer_c;
    logic                           pwm_off_c;

    assign pwm_off_c = (pwm_onoff != PWM_ON);
    assign reg_out   = active;

    // Transfer decision, commit arming and mask-event divider next state
    always_comb begin
        xfer_c    = 1'b0;
        pending_d = pending;
        evt_cnt_d = evt_cnt;
        if (pwm_off_c) begin
            pending_d = 1'b0;
            evt_cnt_d = '0;
        end else begin
            case (update_mode)
                MODE_IMM: xfer_c = pending;
                MODE_EVT: xfer_c = pending & mask_event;
                MODE_DIV: xfer_c = pending & mask_event & (evt_cnt == event_div);
                default:  xfer_c = 1'b0;
            endcase

            if (update_mode != MODE_DIV) begin
                evt_cnt_d = '0;
            end else if (mask_event) begin
                evt_cnt_d = (evt_cnt == event_div) ? '0 : evt_cnt + DIV_W'(1);
            end

            // A commit coinciding with a transfer re-arms for the newer data
            if (commit) begin
                pending_d = 1'b1;
            end else if (xfer_c) begin
                pending_d = 1'b0;
            end
        end
    end

    // Staging registers; out-of-range channel numbers match no entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            staging <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (wr_ch == CH_W'(k)) begin
                    staging[k] <= wr_data;
                end
            end
        end
    end

    // Active registers: track staging while off, bulk copy on transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= '0;
        end else if (pwm_off_c || xfer_c) begin
            active <= staging;
        end
    end

    // Control state and the post-transfer strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= 1'b0;
            evt_cnt      <= '0;
            update_pulse <= 1'b0;
        end else begin
            pending      <= pending_d;
            evt_cnt      <= evt_cnt_d;
            update_pulse <= xfer_c;
        end
    end

endmodule

// File: tb/tb_pwm_shadow_bank.sv
// Scoreboard bench for pwm_shadow_bank: a behavioural model predicts each
// cycle's outputs and every transfer; a monitor process compares them.
module tb_pwm_shadow_bank;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned DIV_W    = 8;
    localparam int unsigned CH_W     = 2;
    localparam int unsigned BUS_W    = CHANNELS * WIDTH;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              pwm_onoff = 1'b0;
    logic              mask_event = 1'b0;
    logic              wr_en = 1'b0;
    logic [CH_W-1:0]   wr_ch = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic              commit = 1'b0;
    logic [1:0]        update_mode = 2'd0;
    logic [DIV_W-1:0]  event_div = '0;
    logic [BUS_W-1:0]  reg_out;
    logic              pending;
    logic              update_pulse;

    pwm_shadow_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DIV_W(DIV_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pwm_onoff    (pwm_onoff),
        .mask_event   (mask_event),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .commit       (commit),
        .update_mode  (update_mode),
        .event_div    (event_div),
        .reg_out      (reg_out),
        .pending      (pending),
        .update_pulse (update_pulse)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [BUS_W-1:0] regs;
        logic             pend;
        logic             upd;
    } exp_t;

    exp_t             exp_q[$];
    logic [BUS_W-1:0] xfer_q[$];

    int checks = 0;
    int errors = 0;

    // Reference state: staging/active contents, armed flag, mask events seen
    logic [WIDTH-1:0] m_stg[CHANNELS];
    logic [WIDTH-1:0] m_act[CHANNELS];
    bit               m_pend = 1'b0;
    bit               m_upd  = 1'b0;
    int               m_ev   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [BUS_W-1:0] pack_act();
        logic [BUS_W-1:0] r;
        for (int k = 0; k < int'(CHANNELS); k++) r[k*WIDTH +: WIDTH] = m_act[k];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < int'(CHANNELS); k++) begin
            m_stg[k] = '0;
            m_act[k] = '0;
        end
        m_pend = 1'b0;
        m_upd  = 1'b0;
        m_ev   = 0;
    endtask

    // Drive one cycle, advance the model, record what the DUT should show
    task automatic step(input bit me, input bit we, input int ch, input logic [WIDTH-1:0] d, input bit cm);
        logic [WIDTH-1:0] old[CHANNELS];
        bit   fire;
        int   div;
        exp_t e;
        mask_event = me;
        wr_en      = we;
        wr_ch      = CH_W'(ch);
        wr_data    = d;
        commit     = cm;
        old  = m_stg;
        fire = 1'b0;
        div  = int'(event_div);
        if (!reset_n) begin
            model_clear();
        end else if (!pwm_onoff) begin
            m_act  = old;
            m_pend = 1'b0;
            m_ev   = 0;
            if (we) m_stg[ch] = d;
        end else begin
            case (update_mode)
                2'd0:    fire = m_pend;
                2'd1:    fire = m_pend && me;
                2'd2:    fire = m_pend && me && ((m_ev % (div + 1)) == div);
                default: fire = 1'b0;
            endcase
            if (update_mode == 2'd2) begin
                if (me) m_ev++;
            end else begin
                m_ev = 0;
            end
            if (fire) begin
                m_act = old;
                xfer_q.push_back(pack_act());
            end
            m_pend = cm ? 1'b1 : (fire ? 1'b0 : m_pend);
            if (we) m_stg[ch] = d;
        end
        m_upd = fire;
        @(posedge clk);
        e.regs = pack_act();
        e.pend = m_pend;
        e.upd  = m_upd;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    // Assert reset between edges; state must clear without waiting for clk
    task automatic do_async_reset();
        reset_n = 1'b0;
        #1;
        model_clear();
        exp_q.delete();
        xfer_q.delete();
        chk("async_rst_regs", 64'(reg_out), 64'd0);
        chk("async_rst_pending", 64'(pending), 64'd0);
        chk("async_rst_pulse", 64'(update_pulse), 64'd0);
    endtask

    // Monitor: per-cycle state compare plus transfer scoreboard on update_pulse
    initial begin
        exp_t e;
        logic [BUS_W-1:0] x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("reg_out", 64'(reg_out), 64'(e.regs));
                chk("pending", 64'(pending), 64'(e.pend));
                chk("update_pulse", 64'(update_pulse), 64'(e.upd));
                if (update_pulse) begin
                    if (xfer_q.size() == 0) begin
                        chk("unexpected_transfer", 64'(1), 64'(0));
                    end else begin
                        x = xfer_q.pop_front();
                        chk("transfer_data", 64'(reg_out), 64'(x));
                    end
                end
            end
        end
    end

    initial begin
        model_clear();

        // Reset held: writes and commits must have no effect
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i, 16'hBEEF, 1'b1);
        chk("rst_regs", 64'(reg_out), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        reset_n = 1'b1;
        idle(2);
        chk("post_rst_regs", 64'(reg_out), 64'd0);

        // PWM off: active follows staging one cycle after the write
        step(1'b0, 1'b1, 2, 16'h1234, 1'b0);
        idle(1);
        chk("off_track_ch2", 64'(reg_out[47:32]), 64'h1234);
        chk("off_no_pulse", 64'(update_pulse), 64'd0);

        // Mode 1: both channels change on the same mask edge
        pwm_onoff   = 1'b1;
        update_mode = 2'd1;
        step(1'b0, 1'b1, 0, 16'h0010, 1'b0);
        step(1'b0, 1'b1, 3, 16'h0FFF, 1'b0);
        step(1'b0, 1'b0, 0, '0, 1'b1);
        idle(4);
        chk("m1_hold_ch0", 64'(reg_out[15:0]), 64'h0000);
        chk("m1_hold_pending", 64'(pending), 64'd1);
        step(1'b1, 1'b0, 0, '0, 1'b0);
        chk("m1_ch0", 64'(reg_out[15:0]), 64'h0010);
        chk("m1_ch3", 64'(reg_out[63:48]), 64'h0FFF);
        chk("m1_pending", 64'(pending), 64'd0);
        chk("m1_pulse", 64'(update_pulse), 64'd1);
        idle(1);
        chk("m1_pulse_end", 64'(update_pulse), 64'd0);

        // Mode 2, divide by 3: only every third event transfers, then wraps
        update_mode = 2'd2;
        event_div   = DIV_W'(2);
        for (int round = 0; round < 2; round++) begin
            step(1'b0, 1'b1, 1, (round == 0) ? 16'h5555 : 16'h6666, 1'b0);
            step(1'b0, 1'b0, 0, '0, 1'b1);
            for (int ev = 1; ev <= 3; ev++) begin
                idle(2);
                step(1'b1, 1'b0, 0, '0, 1'b0);
                if (ev < 3) begin
                    chk("m2_hold_ch1", 64'(reg_out[31:16]), (round == 0) ? 64'h0000 : 64'h5555);
                    chk("m2_hold_pending", 64'(pending), 64'd1);
                end else begin
                    chk("m2_load_ch1", 64'(reg_out[31:16]), (round == 0) ? 64'h5555 : 64'h6666);
                    chk("m2_load_pending", 64'(pending), 64'd0);
                end
            end
        end

        // Collision: write+commit on the transfer edge keeps old data, re-arms
        update_mode = 2'd1;
        step(1'b0, 1'b1, 1, 16'h1111, 1'b0);
        step(1'b0, 1'b0, 0, '0, 1'b1);
        idle(1);
        step(1'b1, 1'b1, 1, 16'hAAAA, 1'b1);
        chk("coll_ch1_old", 64'(reg_out[31:16]), 64'h1111);
        chk("coll_pending", 64'(pending), 64'd1);
        idle(1);
        step(1'b1, 1'b0, 0, '0, 1'b0);
        chk("coll_ch1_new", 64'(reg_out[31:16]), 64'hAAAA);
        chk("coll_pending_clr", 64'(pending), 64'd0);

        // Mode 3 freezes; switching to mode 0 transfers on the next edge
        update_mode = 2'd3;
        step(1'b0, 1'b1, 0, 16'h3333, 1'b0);
        step(1'b0, 1'b0, 0, '0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            step(1'b1, 1'b0, 0, '0, 1'b0);
        end
        chk("m3_ch0", 64'(reg_out[15:0]), 64'h0010);
        chk("m3_pending", 64'(pending), 64'd1);
        update_mode = 2'd0;
        idle(1);
        chk("m0_ch0", 64'(reg_out[15:0]), 64'h3333);
        chk("m0_pending", 64'(pending), 64'd0);

        // Turning PWM off drops pending but staging still reaches the outputs
        update_mode = 2'd3;
        step(1'b0, 1'b1, 3, 16'h7777, 1'b0);
        step(1'b0, 1'b0, 0, '0, 1'b1);
        chk("off_arm_pending", 64'(pending), 64'd1);
        pwm_onoff = 1'b0;
        idle(1);
        chk("off_drop_pending", 64'(pending), 64'd0);
        chk("off_copy_ch3", 64'(reg_out[63:48]), 64'h7777);

        // Randomized traffic against the model, with one async reset midway
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) pwm_onoff = ~pwm_onoff;
            if ($urandom_range(29) == 0) update_mode = 2'($urandom_range(3));
            if (update_mode != 2'd2 && $urandom_range(9) == 0) event_div = DIV_W'($urandom_range(3));
            if (i == 1500) begin
                do_async_reset();
                for (int j = 0; j < 2; j++) step(1'b1, 1'b1, j, 16'($urandom), 1'b1);
                reset_n = 1'b1;
            end
            step($urandom_range(3) == 0, $urandom_range(2) == 0, int'($urandom_range(CHANNELS - 1)),
                 16'($urandom), $urandom_range(7) == 0);
        end

        idle(1);
        @(negedge clk);
        #1;
        chk("xfer_queue_drained", 64'(xfer_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
